// File: rtl/branch_history_table_2bit.sv
// branch_history_table_2bit: untagged table of 2-bit counters that predicts branch direction.
// Lookup is combinational. Updates commit through a one-entry S1 register. A flush clears the table one entry per cycle.
module branch_history_table_2bit #(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned VLEN       = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  input  logic            upd_valid_i,
  input  logic            upd_is_branch_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  output logic            bht_valid_o,
  output logic            bht_taken_o,
  output logic            ready_o
);
  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam logic [IDX_W:0] SWEEP_LAST = (IDX_W+1)'(NR_ENTRIES - 1);
  typedef enum logic {READY, SWEEP} state_e;
  state_e               state_q, state_d;
  logic [IDX_W:0]       sweep_cnt_q, sweep_cnt_d;
  logic [NR_ENTRIES-1:0] valid_q;
  logic [1:0]           cnt_q [NR_ENTRIES];
  logic                 s1_valid_q, s1_taken_q;
  logic [IDX_W-1:0]     s1_idx_q;
  logic [IDX_W-1:0]     look_idx, sweep_idx;
  logic                 s1_capture, s2_we, old_valid;
  logic [1:0]           old_cnt, new_cnt;
  logic                 unused_pc_bits;
  // Only pc[IDX_W:1] selects an entry. The remaining PC bits are not used.
  assign unused_pc_bits = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0], upd_pc_i[VLEN-1:IDX_W+1], upd_pc_i[0]};
  assign look_idx    = vpc_i[IDX_W:1];
  assign sweep_idx   = sweep_cnt_q[IDX_W-1:0];
  assign ready_o     = state_q == READY;
  assign bht_valid_o = ready_o & valid_q[look_idx];
  assign bht_taken_o = bht_valid_o & cnt_q[look_idx][1];
  assign s1_capture  = upd_valid_i & upd_is_branch_i & ~debug_mode_i & ready_o & ~flush_i;
  assign s2_we       = s1_valid_q & ~flush_i;
  assign old_valid   = valid_q[s1_idx_q];
  assign old_cnt     = cnt_q[s1_idx_q];
  always_comb begin
    new_cnt = !old_valid ? (s1_taken_q ? 2'd2 : 2'd1)
            : s1_taken_q ? (old_cnt == 2'd3 ? 2'd3 : old_cnt + 2'd1)
            : (old_cnt == 2'd0 ? 2'd0 : old_cnt - 2'd1);
  end
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    if (flush_i) begin
      state_d     = SWEEP;
      sweep_cnt_d = '0;
    end else if (state_q == SWEEP) begin
      state_d     = sweep_cnt_q == SWEEP_LAST ? READY : SWEEP;
      sweep_cnt_d = sweep_cnt_q == SWEEP_LAST ? '0 : sweep_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= READY;
      sweep_cnt_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_taken_q  <= 1'b0;
      s1_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      s1_valid_q  <= s1_capture;
      s1_taken_q  <= upd_taken_i;
      s1_idx_q    <= upd_pc_i[IDX_W:1];
    end
  end
  // In this write port a sweep clear has priority over a training write to the same entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) cnt_q[i] <= 2'd1;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (state_q == SWEEP && sweep_idx == IDX_W'(i)) begin
          valid_q[i] <= 1'b0;
          cnt_q[i]   <= 2'd1;
        end else if (s2_we && s1_idx_q == IDX_W'(i)) begin
          valid_q[i] <= 1'b1;
          cnt_q[i]   <= new_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_history_table_2bit.sv
// tb_branch_history_table_2bit: directed test of the 2-bit BHT.
// Covers training, saturation, filtering, flush sweep timing, flush collisions and async reset.
module tb_branch_history_table_2bit;
  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, debug_mode_i, upd_valid_i, upd_is_branch_i, upd_taken_i;
  logic [63:0] vpc_i, upd_pc_i;
  logic        bht_valid_o, bht_taken_o, ready_o;
  int          checks = 0;
  int          errors = 0;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] P10  = 64'h8000_0010;
  localparam logic [63:0] P20  = 64'h8000_0020;
  localparam logic [63:0] P40  = 64'h8000_0040;
  localparam logic [63:0] P50  = 64'h8000_0050;
  localparam logic [63:0] P7E  = 64'h8000_007E;

  branch_history_table_2bit #(.NR_ENTRIES(64), .VLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .vpc_i(vpc_i), .upd_valid_i(upd_valid_i), .upd_is_branch_i(upd_is_branch_i),
    .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i), .bht_valid_o(bht_valid_o),
    .bht_taken_o(bht_taken_o), .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic t);
    upd_valid_i     = 1'b1;
    upd_is_branch_i = 1'b1;
    upd_pc_i        = pc;
    upd_taken_i     = t;
  endtask

  task automatic idle();
    upd_valid_i = 1'b0;
    upd_taken_i = 1'b0;
  endtask

  task automatic one_update(input logic [63:0] pc, input logic t);
    drive(pc, t);
    tick();
    idle();
    tick();
  endtask

  task automatic lookup(input logic [63:0] pc);
    vpc_i = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0; upd_pc_i = '0; idle();
    upd_is_branch_i = 1'b0;
    vpc_i = BASE;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    checks++;
    if (bht_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bht_valid_o); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    checks++;
    if (bht_taken_o !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", bht_taken_o); end
  endtask

  task automatic test_back_to_back();
    lookup(P10);
    drive(P10, 1'b1);
    tick();
    checks++;
    if (bht_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass: valid got %b want 0", bht_valid_o); end
    tick();
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b11) begin errors++; $display("FAIL b2b_first: vt got %b want 11", {bht_valid_o, bht_taken_o}); end
    tick();
    idle();
    tick();
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b11) begin errors++; $display("FAIL b2b_saturate: vt got %b want 11", {bht_valid_o, bht_taken_o}); end
    lookup(64'h8000_0090);
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b11) begin errors++; $display("FAIL alias: vt got %b want 11", {bht_valid_o, bht_taken_o}); end
    lookup(64'h8000_0012);
    checks++;
    if (bht_valid_o !== 1'b0) begin errors++; $display("FAIL halfword_idx: valid got %b want 0", bht_valid_o); end
  endtask

  task automatic test_decrement();
    lookup(P10);
    drive(P10, 1'b0);
    tick();
    tick();
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b11) begin errors++; $display("FAIL dec_to_2: vt got %b want 11", {bht_valid_o, bht_taken_o}); end
    idle();
    tick();
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b10) begin errors++; $display("FAIL dec_to_1: vt got %b want 10", {bht_valid_o, bht_taken_o}); end
    one_update(P10, 1'b0);
    one_update(P10, 1'b0);
    one_update(P10, 1'b1);
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b10) begin errors++; $display("FAIL floor_saturate: vt got %b want 10", {bht_valid_o, bht_taken_o}); end
    lookup(P20);
    one_update(P20, 1'b0);
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b10) begin errors++; $display("FAIL init_nt: vt got %b want 10", {bht_valid_o, bht_taken_o}); end
    one_update(P20, 1'b1);
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b11) begin errors++; $display("FAIL init_nt_then_t: vt got %b want 11", {bht_valid_o, bht_taken_o}); end
  endtask

  task automatic test_filtered();
    lookup(P40);
    drive(P40, 1'b1);
    upd_is_branch_i = 1'b0;
    tick();
    idle();
    tick();
    checks++;
    if (bht_valid_o !== 1'b0) begin errors++; $display("FAIL jalr_ignored: valid got %b want 0", bht_valid_o); end
    debug_mode_i = 1'b1;
    one_update(P40, 1'b1);
    checks++;
    if (bht_valid_o !== 1'b0) begin errors++; $display("FAIL debug_ignored: valid got %b want 0", bht_valid_o); end
    debug_mode_i = 1'b0;
    drive(P40, 1'b1);
    tick();
    idle();
    debug_mode_i = 1'b1;
    tick();
    debug_mode_i = 1'b0;
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b11) begin errors++; $display("FAIL debug_late_commit: vt got %b want 11", {bht_valid_o, bht_taken_o}); end
  endtask

  task automatic sweep_len(output int n);
    n = 0;
    while (!ready_o && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic all_invalid(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      lookup(BASE + 64'(i * 2));
      if (bht_valid_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s: %0d valid entries, want 0", name, bad); end
  endtask

  task automatic test_flush();
    int n;
    one_update(BASE, 1'b1);
    one_update(P7E, 1'b1);
    lookup(P7E);
    checks++;
    if (bht_valid_o !== 1'b1) begin errors++; $display("FAIL pre_flush_valid: got %b want 1", bht_valid_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if ({ready_o, bht_valid_o} !== 2'b00) begin errors++; $display("FAIL sweep_outputs: rv got %b want 00", {ready_o, bht_valid_o}); end
    sweep_len(n);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL sweep_len: got %0d cycles want 64", n); end
    all_invalid("flush_cleared");
    one_update(P10, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (30) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    sweep_len(n);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL restart_len: got %0d cycles want 64", n); end
    all_invalid("restart_cleared");
  endtask

  task automatic test_flush_collide();
    int n;
    drive(P40, 1'b1);
    tick();
    drive(P10, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    idle();
    sweep_len(n);
    lookup(P40);
    checks++;
    if (bht_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drops_s2: valid got %b want 0", bht_valid_o); end
    lookup(P10);
    checks++;
    if (bht_valid_o !== 1'b0) begin errors++; $display("FAIL flush_blocks_s1: valid got %b want 0", bht_valid_o); end
  endtask

  task automatic test_reset_mid_sweep();
    one_update(P50, 1'b1);
    lookup(P50);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (10) tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({ready_o, bht_valid_o, bht_taken_o} !== 3'b100) begin errors++; $display("FAIL async_reset: rvt got %b want 100", {ready_o, bht_valid_o, bht_taken_o}); end
    tick();
    rst_ni = 1'b1;
    tick();
    checks++;
    if ({ready_o, bht_valid_o} !== 2'b10) begin errors++; $display("FAIL post_reset: rv got %b want 10", {ready_o, bht_valid_o}); end
    all_invalid("reset_cleared");
    one_update(P50, 1'b0);
    lookup(P50);
    checks++;
    if ({bht_valid_o, bht_taken_o} !== 2'b10) begin errors++; $display("FAIL post_reset_train: vt got %b want 10", {bht_valid_o, bht_taken_o}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_decrement();
    test_filtered();
    test_flush();
    test_flush_collide();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
